alu_cmd_sequencer: RTL and testbench

//  Initiator side of the alu_16bit interface: accepts operation commands over valid/ready,

---
 rtl/alu_cmd_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Initiator side of the external alu_16bit. Accepts operation commands on a
//   valid/ready channel, drives the ALU control inputs, iterates on the ALU
//   for multi-cycle left shifts (shift right is done internally), registers
//   the result and flags, and returns them on a valid/ready response channel.
//
//   Optional build macro: ALU_CMD_STATS_EN adds saturating handshake counters
//   stat_cmd_cnt / stat_err_cnt. Without it the block has no stats ports.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only while idle)
//   cmd_opcode, cmd_a, cmd_b   opcode 0..8 legal, 9..15 flagged as error
//   cmd_shamt                  shift amount for SLL/SRL
//   alu_a, alu_b, alu_carry_in, alu_bnegate, alu_op   to ALU
//   alu_result, alu_carry_out  from ALU (combinational, same cycle)
//   rsp_valid / rsp_ready      response handshake
//   rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err  response payload
//
// States
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_EXEC  | single ALU cycle (or error pass-through for illegal opcodes)
//   ST_SHIFT | one shift step per cycle, r_cnt steps remaining
//   ST_RESP  | response held until rsp_ready
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int STAT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_opcode,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [SHAMT_W-1:0] cmd_shamt,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_carry_in,
    output logic               alu_bnegate,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic               rsp_ovf,
    output logic               rsp_err
`ifdef ALU_CMD_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_cmd_cnt,
    output logic [STAT_W-1:0]  stat_err_cnt
`endif
);

    localparam logic [3:0] OPC_AND = 4'd0;
    localparam logic [3:0] OPC_OR  = 4'd1;
    localparam logic [3:0] OPC_ADD = 4'd2;
    localparam logic [3:0] OPC_SUB = 4'd3;
    localparam logic [3:0] OPC_XOR = 4'd4;
    localparam logic [3:0] OPC_NOR = 4'd5;
    localparam logic [3:0] OPC_SLL = 4'd6;
    localparam logic [3:0] OPC_SRL = 4'd7;
    localparam logic [3:0] OPC_SLT = 4'd8;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]         r_opc;
    logic [WIDTH-1:0]   r_a;      // operand a, doubles as shift accumulator
    logic [WIDTH-1:0]   r_b;
    logic [SHAMT_W-1:0] r_cnt;    // shift steps remaining
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic               r_ovf;
    logic               r_err;

    logic [WIDTH-1:0]   w_alu_a;
    logic [WIDTH-1:0]   w_alu_b;
    logic [2:0]         w_alu_op;
    logic               w_alu_bneg;
    logic               w_alu_cin;

    logic               w_rsp_v;
    logic               w_last_step;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_carry_nxt;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_ovf_addsub;
    logic [WIDTH-1:0]   w_exec_res;
    logic               w_exec_carry;
    logic               w_exec_ovf;
    logic               w_exec_err;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next state ----------------
    assign w_last_step = (r_cnt <= SHAMT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_opcode == OPC_SLL || cmd_opcode == OPC_SRL) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC:  w_state_nxt = ST_RESP;
            ST_SHIFT: begin
                if (w_last_step) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- ALU drive ----------------
    // Everything stays at zero outside EXEC/SHIFT; illegal opcodes and SRL
    // never touch the ALU.
    always_comb begin
        w_alu_a    = '0;
        w_alu_b    = '0;
        w_alu_op   = ALU_AND;
        w_alu_bneg = 1'b0;
        w_alu_cin  = 1'b0;
        if (r_state == ST_EXEC) begin
            case (r_opc)
                OPC_AND: begin w_alu_a = r_a; w_alu_b = r_b; w_alu_op = ALU_AND; end
                OPC_OR:  begin w_alu_a = r_a; w_alu_b = r_b; w_alu_op = ALU_OR;  end
                OPC_ADD: begin w_alu_a = r_a; w_alu_b = r_b; w_alu_op = ALU_ADD; end
                OPC_XOR: begin w_alu_a = r_a; w_alu_b = r_b; w_alu_op = ALU_XOR; end
                OPC_NOR: begin w_alu_a = r_a; w_alu_b = r_b; w_alu_op = ALU_NOR; end
                OPC_SUB, OPC_SLT: begin
                    w_alu_a    = r_a;
                    w_alu_b    = r_b;
                    w_alu_op   = ALU_ADD;
                    w_alu_bneg = 1'b1;
                    w_alu_cin  = 1'b1;
                end
                default: ;
            endcase
        end else if (r_state == ST_SHIFT && r_opc == OPC_SLL) begin
            // acc + acc == acc << 1, carry-out is the bit shifted out
            w_alu_a  = r_a;
            w_alu_b  = r_a;
            w_alu_op = ALU_ADD;
        end
    end

    assign alu_a        = w_alu_a;
    assign alu_b        = w_alu_b;
    assign alu_op       = w_alu_op;
    assign alu_bnegate  = w_alu_bneg;
    assign alu_carry_in = w_alu_cin;

    // ---------------- EXEC result capture ----------------
    assign w_b_eff      = (r_opc == OPC_ADD) ? r_b : ~r_b;
    assign w_ovf_addsub = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                          (alu_result[WIDTH-1] != r_a[WIDTH-1]);

    always_comb begin
        w_exec_res   = alu_result;
        w_exec_carry = 1'b0;
        w_exec_ovf   = 1'b0;
        w_exec_err   = 1'b0;
        case (r_opc)
            OPC_AND, OPC_OR, OPC_XOR, OPC_NOR: ;
            OPC_ADD, OPC_SUB: begin
                w_exec_carry = alu_carry_out;
                w_exec_ovf   = w_ovf_addsub;
            end
            // sign of the difference corrected by overflow gives signed a<b
            OPC_SLT: w_exec_res = {{(WIDTH-1){1'b0}}, alu_result[WIDTH-1] ^ w_ovf_addsub};
            default: begin
                w_exec_res = '0;
                w_exec_err = 1'b1;
            end
        endcase
    end

    // ---------------- shift step ----------------
    // A zero shift amount still spends one SHIFT cycle and leaves acc alone.
    always_comb begin
        w_acc_nxt   = r_a;
        w_carry_nxt = r_carry;
        if (r_cnt != '0) begin
            if (r_opc == OPC_SLL) begin
                w_acc_nxt   = alu_result;
                w_carry_nxt = alu_carry_out;
            end else begin
                w_acc_nxt   = {1'b0, r_a[WIDTH-1:1]};
                w_carry_nxt = r_a[0];
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_opc   <= cmd_opcode;
                        r_a     <= cmd_a;
                        r_b     <= cmd_b;
                        r_cnt   <= cmd_shamt;
                        r_res   <= '0;
                        r_carry <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    r_res   <= w_exec_res;
                    r_carry <= w_exec_carry;
                    r_ovf   <= w_exec_ovf;
                    r_err   <= w_exec_err;
                end
                ST_SHIFT: begin
                    r_a     <= w_acc_nxt;
                    r_carry <= w_carry_nxt;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - SHAMT_W'(1);
                    end
                    if (w_last_step) begin
                        r_res <= w_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- handshake outputs ----------------
    // cmd_ready is qualified by rst_n so it stays low for the whole reset.
    assign cmd_ready  = rst_n && (r_state == ST_IDLE);
    assign w_rsp_v    = (r_state == ST_RESP);
    assign rsp_valid  = w_rsp_v;
    assign rsp_result = w_rsp_v ? r_res : '0;
    assign rsp_carry  = w_rsp_v && r_carry;
    assign rsp_ovf    = w_rsp_v && r_ovf;
    assign rsp_err    = w_rsp_v && r_err;
    assign rsp_zero   = w_rsp_v && !r_err && (r_res == '0);

`ifdef ALU_CMD_STATS_EN
    logic              w_rsp_hs;
    logic [STAT_W-1:0] r_stat_cmd;
    logic [STAT_W-1:0] r_stat_err;

    assign w_rsp_hs = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cmd <= '0;
            r_stat_err <= '0;
        end else if (w_rsp_hs) begin
            if (r_stat_cmd != '1) begin
                r_stat_cmd <= r_stat_cmd + STAT_W'(1);
            end
            if (r_err && r_stat_err != '1) begin
                r_stat_err <= r_stat_err + STAT_W'(1);
            end
        end
    end

    assign stat_cmd_cnt = r_stat_cmd;
    assign stat_err_cnt = r_stat_err;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [3:0]  cmd_shamt = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_carry_in;
    logic        alu_bnegate;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_carry_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_ovf;
    logic        rsp_err;
`ifdef ALU_CMD_STATS_EN
    logic [15:0] stat_cmd_cnt;
    logic [15:0] stat_err_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_opcode    (cmd_opcode),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_shamt     (cmd_shamt),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_carry_in  (alu_carry_in),
        .alu_bnegate   (alu_bnegate),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_carry     (rsp_carry),
        .rsp_zero      (rsp_zero),
        .rsp_ovf       (rsp_ovf),
        .rsp_err       (rsp_err)
`ifdef ALU_CMD_STATS_EN
        ,
        .stat_cmd_cnt  (stat_cmd_cnt),
        .stat_err_cnt  (stat_err_cnt)
`endif
    );

    // ---------------- external ALU (adder runs for every op) ----------------
    logic [15:0] w_bb;
    logic [16:0] w_sum;
    assign w_bb  = alu_bnegate ? ~alu_b : alu_b;
    assign w_sum = {1'b0, alu_a} + {1'b0, w_bb} + {16'b0, alu_carry_in};
    assign alu_carry_out = w_sum[16];
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000:  alu_result = alu_a & w_bb;
            3'b001:  alu_result = alu_a | w_bb;
            3'b010:  alu_result = w_sum[15:0];
            3'b011:  alu_result = alu_a ^ w_bb;
            3'b100:  alu_result = ~(alu_a | w_bb);
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        o;
        logic        e;
    } rsp_t;

    function automatic rsp_t model_rsp(input logic [3:0] op, input logic [15:0] a,
                                       input logic [15:0] b, input logic [3:0] sh);
        rsp_t        r;
        logic [31:0] t;
        int          sa;
        int          sb;
        int          s;
        r  = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd0: r.res = a & b;
            4'd1: r.res = a | b;
            4'd2: begin
                t = 32'(a) + 32'(b);
                r.res = t[15:0];
                r.c = t[16];
                s = sa + sb;
                r.o = (s > 32767) || (s < -32768);
            end
            4'd3: begin
                r.res = a - b;
                r.c = (a >= b);
                s = sa - sb;
                r.o = (s > 32767) || (s < -32768);
            end
            4'd4: r.res = a ^ b;
            4'd5: r.res = ~(a | b);
            4'd6: begin
                t = 32'(a) << sh;
                r.res = t[15:0];
                r.c = t[16];
            end
            4'd7: begin
                t = {a, 16'h0000} >> sh;
                r.res = t[31:16];
                r.c = t[15];
            end
            4'd8: r.res = (sa < sb) ? 16'd1 : 16'd0;
            default: r.e = 1'b1;
        endcase
        r.z = !r.e && (r.res == 16'h0000);
        return r;
    endfunction

    // m_st: 0 idle, 1 busy, 2 response pending
    int          m_st = 0;
    int          m_left = 0;
    int          m_i = 0;
    logic        m_took = 1'b0;
    logic [3:0]  m_op = '0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    rsp_t        m_exp = '0;
    int          m_hs = 0;
    int          m_errhs = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st   = 0;
            m_took = 1'b0;
            m_hs   = 0;
            m_errhs = 0;
        end else begin
            m_took = 1'b0;
            case (m_st)
                0: if (cmd_valid) begin
                    m_op  = cmd_opcode;
                    m_a   = cmd_a;
                    m_b   = cmd_b;
                    m_exp = model_rsp(cmd_opcode, cmd_a, cmd_b, cmd_shamt);
                    m_left = ((cmd_opcode == 4'd6 || cmd_opcode == 4'd7) && cmd_shamt > 4'd1)
                             ? int'(cmd_shamt) : 1;
                    m_i    = 0;
                    m_st   = 1;
                    m_took = 1'b1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_st = 2;
                    else m_i++;
                end
                default: if (rsp_ready) begin
                    m_st = 0;
                    m_hs++;
                    if (m_exp.e) m_errhs++;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : p_check
        logic [15:0] ea;
        logic [15:0] eb;
        logic [2:0]  eop;
        logic        ebn;
        ea = '0; eb = '0; eop = '0; ebn = 1'b0;
        if (m_st == 1) begin
            case (m_op)
                4'd0: begin ea = m_a; eb = m_b; eop = 3'd0; end
                4'd1: begin ea = m_a; eb = m_b; eop = 3'd1; end
                4'd2: begin ea = m_a; eb = m_b; eop = 3'd2; end
                4'd3, 4'd8: begin ea = m_a; eb = m_b; eop = 3'd2; ebn = 1'b1; end
                4'd4: begin ea = m_a; eb = m_b; eop = 3'd3; end
                4'd5: begin ea = m_a; eb = m_b; eop = 3'd4; end
                4'd6: begin ea = m_a << m_i; eb = ea; eop = 3'd2; end
                default: ;
            endcase
        end
        chk("cmd_ready", cmd_ready, rst_n && m_st == 0);
        chk("rsp_valid", rsp_valid, m_st == 2);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_op, eop);
        chk("alu_bnegate", alu_bnegate, ebn);
        chk("alu_carry_in", alu_carry_in, ebn);
        if (m_st == 2) begin
            chk("rsp_result", rsp_result, m_exp.res);
            chk("rsp_carry", rsp_carry, m_exp.c);
            chk("rsp_zero", rsp_zero, m_exp.z);
            chk("rsp_ovf", rsp_ovf, m_exp.o);
            chk("rsp_err", rsp_err, m_exp.e);
        end
`ifdef ALU_CMD_STATS_EN
        chk("stat_cmd_cnt", stat_cmd_cnt, m_hs);
        chk("stat_err_cnt", stat_err_cnt, m_errhs);
`endif
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] sh, input int hold,
                           output int lat, output rsp_t got, output logic ex_bn, output logic ex_cin);
        int n;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_shamt  = sh;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_took && n < 20);
        cmd_valid = 1'b0;
        chk("accept", m_took, 1);
        ex_bn  = alu_bnegate;
        ex_cin = alu_carry_in;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_seen", rsp_valid, 1);
        got = {rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err};
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_result", rsp_result, got.res);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin : p_main
        int   lat;
        rsp_t got;
        logic bn;
        logic ci;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1);

        run_cmd(4'd2, 16'h7FFF, 16'h0001, 4'd0, 0, lat, got, bn, ci);
        chk("add_lat", lat, 1);
        chk("add_res", got.res, 16'h8000);
        chk("add_ovf", got.o, 1);
        chk("add_carry", got.c, 0);
        chk("add_zero", got.z, 0);

        run_cmd(4'd3, 16'h0005, 16'h0005, 4'd0, 1, lat, got, bn, ci);
        chk("sub_res", got.res, 16'h0000);
        chk("sub_zero", got.z, 1);
        chk("sub_carry", got.c, 1);
        chk("sub_ovf", got.o, 0);
        chk("sub_bnegate", bn, 1);
        chk("sub_carry_in", ci, 1);

        run_cmd(4'd6, 16'h8001, 16'h0000, 4'd3, 0, lat, got, bn, ci);
        chk("sll_lat", lat, 3);
        chk("sll_res", got.res, 16'h0008);
        chk("sll_carry", got.c, 0);

        run_cmd(4'd7, 16'h0005, 16'h0000, 4'd1, 0, lat, got, bn, ci);
        chk("srl_lat", lat, 1);
        chk("srl_res", got.res, 16'h0002);
        chk("srl_carry", got.c, 1);

        run_cmd(4'd7, 16'h1234, 16'h0000, 4'd0, 0, lat, got, bn, ci);
        chk("srl0_lat", lat, 1);
        chk("srl0_res", got.res, 16'h1234);
        chk("srl0_carry", got.c, 0);

        run_cmd(4'd6, 16'hABCD, 16'h0000, 4'd0, 0, lat, got, bn, ci);
        chk("sll0_lat", lat, 1);
        chk("sll0_res", got.res, 16'hABCD);

        run_cmd(4'hC, 16'h1111, 16'h2222, 4'd0, 5, lat, got, bn, ci);
        chk("ill_lat", lat, 1);
        chk("ill_err", got.e, 1);
        chk("ill_res", got.res, 16'h0000);

        // remaining ops checked against the model only
        run_cmd(4'd0, 16'hF0F0, 16'h3C3C, 4'd0, 0, lat, got, bn, ci);
        run_cmd(4'd1, 16'hF000, 16'h000F, 4'd0, 0, lat, got, bn, ci);
        run_cmd(4'd4, 16'hFFFF, 16'h00FF, 4'd0, 0, lat, got, bn, ci);
        run_cmd(4'd5, 16'h0000, 16'h0000, 4'd0, 0, lat, got, bn, ci);
        run_cmd(4'd3, 16'h0003, 16'h0005, 4'd0, 0, lat, got, bn, ci);
        run_cmd(4'd3, 16'h8000, 16'h0001, 4'd0, 0, lat, got, bn, ci);
        run_cmd(4'd8, 16'hFFFF, 16'h0001, 4'd0, 0, lat, got, bn, ci);
        chk("slt_neg_res", got.res, 16'h0001);
        run_cmd(4'd8, 16'h0005, 16'h0003, 4'd0, 0, lat, got, bn, ci);
        run_cmd(4'd8, 16'h7FFF, 16'h8000, 4'd0, 2, lat, got, bn, ci);
        run_cmd(4'd6, 16'h0003, 16'h0000, 4'd15, 0, lat, got, bn, ci);
        chk("sll15_lat", lat, 15);
        chk("sll15_res", got.res, 16'h8000);
        chk("sll15_carry", got.c, 1);
        run_cmd(4'd7, 16'h8000, 16'h0000, 4'd15, 0, lat, got, bn, ci);
        run_cmd(4'hF, 16'hFFFF, 16'hFFFF, 4'd7, 0, lat, got, bn, ci);

        // reset in the middle of a long shift
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_opcode = 4'd6;
        cmd_a      = 16'h0001;
        cmd_b      = 16'h0000;
        cmd_shamt  = 4'd15;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("mid_accept", m_took, 1);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_alu_a", alu_a, 16'h0010);
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 16'h0000);
        chk("rst_alu_op", alu_op, 3'b000);
        chk("rst_cmd_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        run_cmd(4'd2, 16'h0002, 16'h0003, 4'd0, 0, lat, got, bn, ci);
        chk("after_rst_lat", lat, 1);
        chk("after_rst_res", got.res, 16'h0005);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
